// File: rtl/regbank_ctrl.sv
//------------------------------------------------------------------------------
// Module      : regbank_ctrl
// Description : Multi-cycle instruction sequencer for the 16 x 16-bit register
//               bank and ALU. Accepts one 16-bit instruction over a
//               valid/ready handshake, walks IDLE -> DECODE -> EXEC -> WB, and
//               drives read selects, ALU opcode, immediate and a one-hot
//               register write enable.
// Option      : REGCTRL_R0_ZERO_EN - when defined, r0 is read-only (no reg_en
//               bit is ever raised for Rdest = 0).
// Ports       : clk, reset        - clock, synchronous active-high reset
//               instr_valid_i     - instruction word present on instr_i
//               instr_i[15:0]     - [15:12] op, [11:8] Rdest, [7:4] ext,
//                                   [3:0] Rsrc, [7:0] imm8 (I-type)
//               instr_ready_o     - high only in IDLE
//               reg_en_o[15:0]    - one-hot register write enable (WB only)
//               srcA_sel_o[3:0]   - operand A read select (Rdest)
//               srcB_sel_o[3:0]   - operand B read select (Rsrc)
//               imm_sel_o         - operand B from immediate when 1
//               imm_o             - extended immediate
//               alu_op_o[3:0]     - ALU function code
//               flag_we_o         - flag register write strobe (WB only)
//               done_o            - one-cycle pulse at WB of a legal op
//               illegal_o         - one-cycle pulse on undefined encoding
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regbank_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid_i,
  input  logic [15:0]           instr_i,
  output logic                  instr_ready_o,
  output logic [15:0]           reg_en_o,
  output logic [3:0]            srcA_sel_o,
  output logic [3:0]            srcB_sel_o,
  output logic                  imm_sel_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [3:0]            alu_op_o,
  output logic                  flag_we_o,
  output logic                  done_o,
  output logic                  illegal_o
);

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_MOV   = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  // Decoded fields of the latched instruction
  logic [3:0]  op, rd, ext, rs, code;
  logic        rtype, legal, is_logic, is_cmp, sets_flags, writes_reg;

  function automatic logic code_defined(input logic [3:0] c);
    return (c == OP_ADD) || (c == OP_SUB) || (c == OP_CMP) || (c == OP_AND) ||
           (c == OP_OR)  || (c == OP_XOR) || (c == OP_MOV);
  endfunction

  always_comb begin
    op         = ir_q[15:12];
    rd         = ir_q[11:8];
    ext        = ir_q[7:4];
    rs         = ir_q[3:0];
    rtype      = (op == OP_RTYPE);
    // R-type carries the function in ext; I-type reuses the same codes as op
    code       = rtype ? ext : op;
    legal      = code_defined(code);
    is_logic   = (code == OP_AND) || (code == OP_OR) || (code == OP_XOR);
    is_cmp     = (code == OP_CMP);
    sets_flags = (code == OP_ADD) || (code == OP_SUB) || is_cmp;
`ifdef REGCTRL_R0_ZERO_EN
    writes_reg = legal && !is_cmp && (rd != 4'd0);
`else
    writes_reg = legal && !is_cmp;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and outputs
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    illegal_d     = 1'b0;
    instr_ready_o = 1'b0;
    reg_en_o      = 16'h0000;
    srcA_sel_o    = 4'd0;
    srcB_sel_o    = 4'd0;
    imm_sel_o     = 1'b0;
    imm_o         = '0;
    alu_op_o      = 4'd0;
    flag_we_o     = 1'b0;
    done_o        = 1'b0;
    illegal_o     = illegal_q;

    if (state_q != S_IDLE) begin
      srcA_sel_o = rd;
      srcB_sel_o = rs;
      imm_sel_o  = !rtype;
      alu_op_o   = code;
      if (!rtype) begin
        imm_o = is_logic ? {{(DATA_WIDTH-8){1'b0}}, ir_q[7:0]}
                         : {{(DATA_WIDTH-8){ir_q[7]}}, ir_q[7:0]};
      end
    end

    case (state_q)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          ir_d    = instr_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          // Pulse appears in the following IDLE cycle
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        done_o    = 1'b1;
        flag_we_o = sets_flags;
        if (writes_reg) begin
          reg_en_o = 16'h0001 << rd;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_regbank_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_regbank_ctrl
// Description : Directed self-checking bench for regbank_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regbank_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid_i = 1'b0;
  logic [15:0] instr_i = 16'h0000;
  logic        instr_ready_o;
  logic [15:0] reg_en_o;
  logic [3:0]  srcA_sel_o, srcB_sel_o, alu_op_o;
  logic        imm_sel_o, flag_we_o, done_o, illegal_o;
  logic [15:0] imm_o;

  int passed = 0;
  int total  = 0;

  regbank_ctrl #(.DATA_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_ready_o (instr_ready_o),
    .reg_en_o      (reg_en_o),
    .srcA_sel_o    (srcA_sel_o),
    .srcB_sel_o    (srcB_sel_o),
    .imm_sel_o     (imm_sel_o),
    .imm_o         (imm_o),
    .alu_op_o      (alu_op_o),
    .flag_we_o     (flag_we_o),
    .done_o        (done_o),
    .illegal_o     (illegal_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample and drive 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one legal instruction from IDLE and check every cycle through WB
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] exp_en,
                           input logic exp_flag, input logic exp_isel,
                           input logic [15:0] exp_imm, input logic [3:0] exp_alu);
    instr_i       = ins;
    instr_valid_i = 1'b1;
    step();                                   // accept edge -> cycle 1 (DECODE)
    instr_valid_i = 1'b0;
    instr_i       = 16'hFFFF;                 // must be ignored while busy
    chk("c1_ready",  instr_ready_o, 0);
    chk("c1_srcA",   srcA_sel_o, ins[11:8]);
    chk("c1_alu",    alu_op_o, exp_alu);
    chk("c1_reg_en", reg_en_o, 0);
    step();                                   // cycle 2 (EXEC)
    chk("c2_reg_en", reg_en_o, 0);
    chk("c2_done",   done_o, 0);
    step();                                   // cycle 3 (WB)
    chk("wb_reg_en", reg_en_o, exp_en);
    chk("wb_flag",   flag_we_o, exp_flag);
    chk("wb_done",   done_o, 1);
    chk("wb_illeg",  illegal_o, 0);
    chk("wb_srcA",   srcA_sel_o, ins[11:8]);
    chk("wb_srcB",   srcB_sel_o, ins[3:0]);
    chk("wb_isel",   imm_sel_o, exp_isel);
    chk("wb_alu",    alu_op_o, exp_alu);
    if (exp_isel) chk("wb_imm", imm_o, exp_imm);
    step();                                   // cycle 4 (IDLE)
    chk("c4_ready",  instr_ready_o, 1);
    chk("c4_reg_en", reg_en_o, 0);
    chk("c4_done",   done_o, 0);
    chk("c4_srcA",   srcA_sel_o, 0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_ready", instr_ready_o, 1);
    chk("rst_reg_en", reg_en_o, 0);
    chk("rst_alu", alu_op_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_illeg", illegal_o, 0);
    reset = 1'b0;
    step();

    // ADD R3,R2
    run_instr(16'h0352, 16'h0008, 1'b1, 1'b0, 16'h0000, 4'b0101);
    // ADDI R7,-16 (sign-extended)
    run_instr(16'h57F0, 16'h0080, 1'b1, 1'b1, 16'hFFF0, 4'b0101);
    // ANDI R7,0xF0 (zero-extended, no flags)
    run_instr(16'h17F0, 16'h0080, 1'b0, 1'b1, 16'h00F0, 4'b0001);
    // CMP R4,R1: flags only, no register write
    run_instr(16'h04B1, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b1011);
    // XOR R10,R1
    run_instr(16'h0A31, 16'h0400, 1'b0, 1'b0, 16'h0000, 4'b0011);
    // SUBI R12,-128
    run_instr(16'h9C80, 16'h1000, 1'b1, 1'b1, 16'hFF80, 4'b1001);
    // MOV R15,R2
    run_instr(16'h0FD2, 16'h8000, 1'b0, 1'b0, 16'h0000, 4'b1101);
    // CMPI R2,0x7F (positive sign extension)
    run_instr(16'hB27F, 16'h0000, 1'b1, 1'b1, 16'h007F, 4'b1011);
    // MOVI R0,5
`ifdef REGCTRL_R0_ZERO_EN
    run_instr(16'hD005, 16'h0000, 1'b0, 1'b1, 16'h0005, 4'b1101);
`else
    run_instr(16'hD005, 16'h0001, 1'b0, 1'b1, 16'h0005, 4'b1101);
`endif

    // Illegal R-type ext 0111, then next instruction accepted in cycle 2
    instr_i       = 16'h0E75;
    instr_valid_i = 1'b1;
    step();
    instr_valid_i = 1'b0;
    chk("il_c1_ready", instr_ready_o, 0);
    chk("il_c1_illeg", illegal_o, 0);
    step();
    chk("il_c2_illeg", illegal_o, 1);
    chk("il_c2_ready", instr_ready_o, 1);
    chk("il_c2_reg_en", reg_en_o, 0);
    chk("il_c2_done", done_o, 0);
    run_instr(16'h0352, 16'h0008, 1'b1, 1'b0, 16'h0000, 4'b0101);

    // Illegal op 0111
    instr_i       = 16'h7123;
    instr_valid_i = 1'b1;
    step();
    instr_valid_i = 1'b0;
    step();
    chk("ilop_illeg", illegal_o, 1);
    chk("ilop_done", done_o, 0);
    step();
    chk("ilop_clear", illegal_o, 0);

    // Reset asserted in EXEC discards the instruction
    instr_i       = 16'h0352;
    instr_valid_i = 1'b1;
    step();                                   // DECODE
    instr_valid_i = 1'b0;
    step();                                   // EXEC
    reset = 1'b1;
    step();
    chk("rx_ready", instr_ready_o, 1);
    chk("rx_srcA", srcA_sel_o, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rx_reg_en", reg_en_o, 0);
      chk("rx_done", done_o, 0);
    end

    // Reset dominates a simultaneous transfer
    reset         = 1'b1;
    instr_valid_i = 1'b1;
    instr_i       = 16'h0352;
    step();
    reset         = 1'b0;
    instr_valid_i = 1'b0;
    chk("rd_ready", instr_ready_o, 1);
    step();
    chk("rd_ready2", instr_ready_o, 1);
    step();
    step();
    chk("rd_done", done_o, 0);

    // Continuous valid: one accept every 4 cycles
    instr_i       = 16'h0352;
    instr_valid_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("bb_ready", instr_ready_o, ((k % 4) == 0) ? 1 : 0);
      chk("bb_done", done_o, ((k % 4) == 3) ? 1 : 0);
      chk("bb_reg_en", reg_en_o, ((k % 4) == 3) ? 32'h0008 : 0);
    end
    instr_valid_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
